// File: rtl/snake_board_scanner_if.sv
// Pixel stream interface between the board scanner and the display driver.
// One beat per cell: 16-bit pixel word plus start-of-frame and end-of-line markers,
// transferred on a valid/ready handshake.
interface snake_board_scanner_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic        sof;
    logic        eol;

    // Producer side (scanner)
    modport master (
        output valid,
        output data,
        output sof,
        output eol,
        input  ready
    );

    // Consumer side (display driver)
    modport slave (
        input  valid,
        input  data,
        input  sof,
        input  eol,
        output ready
    );
endinterface

// File: rtl/snake_board_scanner.sv
// GreedySnake board scanner: reads the cell map through BSRAM port B in raster
// order once per frame request and streams one pixel beat per cell.
// Read latency is absorbed by a tag pipe feeding a small skid FIFO; reads are only
// issued when the FIFO is guaranteed room for them, so the stream sustains 1 beat/clk.
// Optional feature macro: SNAKE_SCANNER_COLOR_LUT_EN
//   defined   -> pixel word is RGB565 from a fixed cell-code colour table
//   undefined -> pixel word is {8'h00, cell_code}
module snake_board_scanner #(
    parameter int          WIDTH        = 32,
    parameter int          HEIGHT       = 24,
    parameter int          ROW_STRIDE   = 32,
    parameter logic [10:0] BASE_ADDR    = 11'd0,
    parameter int          READ_LATENCY = 2,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_b_clk_en,
    output logic        o_b_data_en,
    output logic        o_b_wr_en,
    output logic [10:0] o_b_address,
    output logic [7:0]  o_b_data,
    input  logic [7:0]  i_b_data,
    snake_board_scanner_if.master pix
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(READ_LATENCY + 1);
    // FIFO entry layout: {pixel[15:0], sof, eol}
    localparam int EW = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_sof_q;
    logic [READ_LATENCY-1:0] pipe_eol_q;

    logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     fifo_count_q;

    logic [OW-1:0]     outstanding;
    logic              can_issue;
    logic              issue;
    logic              tag_sof;
    logic              tag_eol;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [15:0]       push_pix;
    logic [EW-1:0]     head;

    // Port B is read-only and permanently enabled so the read latency is fixed.
    assign o_b_clk_en  = 1'b1;
    assign o_b_data_en = 1'b1;
    assign o_b_wr_en   = 1'b0;
    assign o_b_data    = 8'h00;

    // Address of the current cell; wraps within the 2K BSRAM space.
    assign o_b_address = 11'(int'(BASE_ADDR) + int'(y_q) * ROW_STRIDE + int'(x_q));

    assign tag_sof = (x_q == '0) && (y_q == '0);
    assign tag_eol = (x_q == XW'(WIDTH - 1));

    // Count reads in flight through the tag pipe.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + OW'(pipe_vld_q[i]);
        end
    end

    // Credit check: every read in flight plus every buffered beat must fit in the FIFO.
    // Same-cycle pops are not credited, which keeps the push side free of a full check.
    assign can_issue = (int'(outstanding) + int'(fifo_count_q)) < FIFO_DEPTH;

    // Next-state logic: frame sequencing, raster counters and read issue.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(HEIGHT - 1)) begin
                            // Last cell issued; park the address back on cell (0,0).
                            y_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Frame ends when the final buffered beat leaves and nothing is in flight.
                if (pop && (fifo_count_q == CW'(1)) && (outstanding == '0)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

    // Tag pipe: follows each read through the BSRAM so its output lines up with i_b_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_sof_q <= '0;
            pipe_eol_q <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_sof_q[i] <= pipe_sof_q[i-1];
                pipe_eol_q[i] <= pipe_eol_q[i-1];
            end
            pipe_vld_q[0] <= issue;
            pipe_sof_q[0] <= tag_sof;
            pipe_eol_q[0] <= tag_eol;
        end
    end

    assign push = pipe_vld_q[READ_LATENCY-1];

    // Cell code to pixel word, applied as the beat enters the FIFO.
    always_comb begin
`ifdef SNAKE_SCANNER_COLOR_LUT_EN
        case (i_b_data)
            8'd0:    push_pix = 16'h0000;  // empty
            8'd1:    push_pix = 16'h07E0;  // body
            8'd2:    push_pix = 16'hFFE0;  // head
            8'd3:    push_pix = 16'hF800;  // food
            8'd4:    push_pix = 16'h8410;  // wall
            default: push_pix = 16'hF81F;  // unknown code
        endcase
`else
        push_pix = {8'h00, i_b_data};
`endif
    end

    assign fifo_valid = (fifo_count_q != '0);
    assign pop        = fifo_valid && pix.ready;
    assign head       = fifo_mem_q[rd_ptr_q];

    // Skid FIFO: pointers and occupancy; entry storage is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {push_pix, pipe_sof_q[READ_LATENCY-1], pipe_eol_q[READ_LATENCY-1]};
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_count_q <= fifo_count_q + 1'b1;
            end else if (!push && pop) begin
                fifo_count_q <= fifo_count_q - 1'b1;
            end
        end
    end

    // Stream outputs are forced to zero whenever no beat is offered.
    assign pix.valid = fifo_valid;
    assign pix.data  = fifo_valid ? head[17:2] : 16'h0000;
    assign pix.sof   = fifo_valid ? head[1]    : 1'b0;
    assign pix.eol   = fifo_valid ? head[0]    : 1'b0;

`ifndef SYNTHESIS
    // A push into a full FIFO means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (fifo_count_q == CW'(FIFO_DEPTH))));
        end
    end
`endif

endmodule
